// File: rtl/instruction_cache_if.sv
// Fetcher-side and memory-side valid/ready read bus of the instruction cache.
interface instruction_cache_if #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   fetch_read_valid;
    logic [ADDR_WIDTH-1:0]  fetch_read_address;
    logic                   fetch_read_ready;
    logic [INSTR_WIDTH-1:0] fetch_read_data;
    logic                   mem_read_valid;
    logic [ADDR_WIDTH-1:0]  mem_read_address;
    logic                   mem_read_ready;
    logic [INSTR_WIDTH-1:0] mem_read_data;

    modport slave (
        input  fetch_read_valid, fetch_read_address, mem_read_ready, mem_read_data,
        output fetch_read_ready, fetch_read_data, mem_read_valid, mem_read_address
    );

    modport master (
        output fetch_read_valid, fetch_read_address, mem_read_ready, mem_read_data,
        input  fetch_read_ready, fetch_read_data, mem_read_valid, mem_read_address
    );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache, one instruction per line.
// Optional hit/miss counters enabled by defining ICACHE_STATS_EN.
module instruction_cache #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned NUM_LINES   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
`ifdef ICACHE_STATS_EN
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count,
`endif
    instruction_cache_if.slave  bus
);
    localparam int unsigned INDEX_BITS = $clog2(NUM_LINES);
    localparam int unsigned TAG_BITS   = ADDR_WIDTH - INDEX_BITS;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_MISS   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]             r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_req_addr, w_req_addr_nxt;
    logic [NUM_LINES-1:0]   r_valid;
    logic [TAG_BITS-1:0]    r_tag  [NUM_LINES];
    logic [INSTR_WIDTH-1:0] r_data [NUM_LINES];

    logic                   r_fetch_ready, w_fetch_ready_nxt;
    logic [INSTR_WIDTH-1:0] r_fetch_data, w_fetch_data_nxt;
    logic                   r_mem_valid, w_mem_valid_nxt;
    logic [ADDR_WIDTH-1:0]  r_mem_addr, w_mem_addr_nxt;

    logic [INDEX_BITS-1:0]  w_index;
    logic [TAG_BITS-1:0]    w_tag;
    logic                   w_hit;
    logic                   w_fill;

    assign w_index = r_req_addr[INDEX_BITS-1:0];
    assign w_tag   = r_req_addr[ADDR_WIDTH-1:INDEX_BITS];
    assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);

    assign bus.fetch_read_ready = r_fetch_ready;
    assign bus.fetch_read_data  = r_fetch_data;
    assign bus.mem_read_valid   = r_mem_valid;
    assign bus.mem_read_address = r_mem_addr;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt       = r_state;
        w_req_addr_nxt    = r_req_addr;
        w_fetch_ready_nxt = 1'b0;
        w_fetch_data_nxt  = r_fetch_data;
        w_mem_valid_nxt   = r_mem_valid;
        w_mem_addr_nxt    = r_mem_addr;
        w_fill            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.fetch_read_valid) begin
                    w_req_addr_nxt = bus.fetch_read_address;
                    w_state_nxt    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    w_fetch_ready_nxt = 1'b1;
                    w_fetch_data_nxt  = r_data[w_index];
                    w_state_nxt       = S_DONE;
                end else begin
                    w_mem_valid_nxt = 1'b1;
                    w_mem_addr_nxt  = r_req_addr;
                    w_state_nxt     = S_MISS;
                end
            end
            S_MISS: begin
                if (bus.mem_read_ready) begin
                    w_fill            = 1'b1;
                    w_mem_valid_nxt   = 1'b0;
                    w_fetch_ready_nxt = 1'b1;
                    w_fetch_data_nxt  = bus.mem_read_data;
                    w_state_nxt       = S_DONE;
                end
            end
            S_DONE: begin
                // Wait for the fetcher to drop valid so a held request is not served twice
                if (!bus.fetch_read_valid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_addr    <= '0;
            r_fetch_ready <= 1'b0;
            r_fetch_data  <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_addr    <= '0;
            r_valid       <= '0;
        end else begin
            r_req_addr    <= w_req_addr_nxt;
            r_fetch_ready <= w_fetch_ready_nxt;
            r_fetch_data  <= w_fetch_data_nxt;
            r_mem_valid   <= w_mem_valid_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            // Flush overrides a fill landing on the same edge
            if (flush)       r_valid          <= '0;
            else if (w_fill) r_valid[w_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill && !reset) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= bus.mem_read_data;
        end
    end

`ifdef ICACHE_STATS_EN
    logic w_count_hit, w_count_miss;
    assign w_count_hit  = (r_state == S_LOOKUP) &&  w_hit;
    assign w_count_miss = (r_state == S_LOOKUP) && !w_hit;

    // Saturating lookup counters; cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (w_count_hit  && (hit_count  != 32'hFFFF_FFFF)) hit_count  <= hit_count  + 32'd1;
            if (w_count_miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: vector table plus scoreboard of fetch responses.
module tb_instruction_cache;
    logic clk = 1'b0;
    logic reset;
    logic flush;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    instruction_cache_if #(.ADDR_WIDTH(12), .INSTR_WIDTH(32)) bus ();

    instruction_cache #(.ADDR_WIDTH(12), .INSTR_WIDTH(32), .NUM_LINES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
`ifdef ICACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        bit          miss;
        logic [31:0] data;
        int          lat;
        bit          pre_flush;
        bit          flush_fill;
        int          hold;
    } vec_t;

    vec_t        vecs [16];
    logic [31:0] sb [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pulse = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every response pulse pops one expected instruction
    always @(negedge clk) begin
        if (!reset && bus.fetch_read_ready) begin
            n_pulse++;
            if (sb.size() == 0) check("unexpected_pulse", 32'd1, 32'd0);
            else                check("rdata", bus.fetch_read_data, sb.pop_front());
        end
    end

    task automatic access(input vec_t v);
        int  t;
        int  mem_cnt;
        int  ready_t;
        int  p0;
        bit  seen_mem;
        bit  got;
        bit  rdy_driven;
        t = 0; mem_cnt = 0; ready_t = 0; seen_mem = 0; got = 0; rdy_driven = 0;
        if (v.pre_flush) begin
            @(negedge clk) flush = 1'b1;
            @(negedge clk) flush = 1'b0;
        end
        @(negedge clk);
        p0 = n_pulse;
        bus.fetch_read_valid   = 1'b1;
        bus.fetch_read_address = v.addr;
        sb.push_back(v.data);
        while (!got && t < 200) begin
            @(negedge clk);
            t++;
            if (rdy_driven) begin
                check("miss_lat", 32'(bus.fetch_read_ready), 32'd1);
                check("mem_valid_drop", 32'(bus.mem_read_valid), 32'd0);
                bus.mem_read_ready = 1'b0;
                flush = 1'b0;
                rdy_driven = 0;
            end
            if (bus.mem_read_valid) begin
                if (!seen_mem) begin
                    seen_mem = 1;
                    check("mem_addr", 32'(bus.mem_read_address), 32'(v.addr));
                end
                mem_cnt++;
                if (mem_cnt == v.lat) begin
                    bus.mem_read_ready = 1'b1;
                    bus.mem_read_data  = v.data;
                    flush = v.flush_fill;
                    rdy_driven = 1;
                end
            end
            if (bus.fetch_read_ready) begin
                got = 1;
                ready_t = t;
            end
        end
        check("timeout", 32'(got), 32'd1);
        check("miss_flag", 32'(seen_mem), 32'(v.miss));
        if (!v.miss) check("hit_lat", 32'(ready_t), 32'd2);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check("held_no_mem", 32'(bus.mem_read_valid), 32'd0);
        end
        bus.fetch_read_valid   = 1'b0;
        bus.fetch_read_address = 12'h000;
        @(negedge clk);
        check("one_pulse", 32'(n_pulse - p0), 32'd1);
        if (v.miss) exp_misses++;
        else        exp_hits++;
    endtask

    initial begin
        vecs[0]  = '{12'h005, 1'b1, 32'hDEADBEEF, 3, 1'b0, 1'b0, 0};
        vecs[1]  = '{12'h005, 1'b0, 32'hDEADBEEF, 0, 1'b0, 1'b0, 0};
        vecs[2]  = '{12'h015, 1'b1, 32'h12345678, 2, 1'b0, 1'b0, 0};
        vecs[3]  = '{12'h005, 1'b1, 32'hDEADBEEF, 1, 1'b0, 1'b0, 0};
        vecs[4]  = '{12'h015, 1'b1, 32'h12345678, 1, 1'b0, 1'b0, 0};
        vecs[5]  = '{12'h003, 1'b1, 32'hAAAA0003, 1, 1'b0, 1'b0, 0};
        vecs[6]  = '{12'h003, 1'b0, 32'hAAAA0003, 0, 1'b0, 1'b0, 0};
        vecs[7]  = '{12'h003, 1'b1, 32'hAAAA0003, 2, 1'b1, 1'b0, 0};
        vecs[8]  = '{12'h003, 1'b0, 32'hAAAA0003, 0, 1'b0, 1'b0, 0};
        vecs[9]  = '{12'h00A, 1'b1, 32'hCAFEF00D, 2, 1'b0, 1'b1, 0};
        vecs[10] = '{12'h00A, 1'b1, 32'hCAFEF00D, 1, 1'b0, 1'b0, 0};
        vecs[11] = '{12'h00A, 1'b0, 32'hCAFEF00D, 0, 1'b0, 1'b0, 4};
        vecs[12] = '{12'h003, 1'b1, 32'h33330003, 1, 1'b0, 1'b0, 0};
        vecs[13] = '{12'hFFF, 1'b1, 32'h0BADF00D, 1, 1'b0, 1'b0, 0};
        vecs[14] = '{12'hFFF, 1'b0, 32'h0BADF00D, 0, 1'b0, 1'b0, 0};
        vecs[15] = '{12'h00F, 1'b1, 32'h0F0F0F0F, 1, 1'b0, 1'b0, 0};

        reset = 1'b1;
        flush = 1'b0;
        bus.fetch_read_valid   = 1'b0;
        bus.fetch_read_address = 12'h000;
        bus.mem_read_ready     = 1'b0;
        bus.mem_read_data      = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_fetch_ready", 32'(bus.fetch_read_ready), 32'd0);
        check("rst_fetch_data", bus.fetch_read_data, 32'd0);
        check("rst_mem_valid", 32'(bus.mem_read_valid), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_read_address), 32'd0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif

        for (int i = 0; i < 16; i++) access(vecs[i]);

`ifdef ICACHE_STATS_EN
        check("hit_count", hit_count, 32'(exp_hits));
        check("miss_count", miss_count, 32'(exp_misses));
`endif

        // Reset while waiting on memory, then a late memory response
        begin
            int  t;
            int  p0;
            bit  seen;
            t = 0; seen = 0;
            @(negedge clk);
            bus.fetch_read_valid   = 1'b1;
            bus.fetch_read_address = 12'h020;
            while (!seen && t < 50) begin
                @(negedge clk);
                t++;
                seen = bus.mem_read_valid;
            end
            check("rst_miss_timeout", 32'(seen), 32'd1);
            p0 = n_pulse;
            reset = 1'b1;
            bus.fetch_read_valid = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            check("rst_mid_mem_valid", 32'(bus.mem_read_valid), 32'd0);
            check("rst_mid_fetch_ready", 32'(bus.fetch_read_ready), 32'd0);
`ifdef ICACHE_STATS_EN
            check("rst_mid_hit_count", hit_count, 32'd0);
            check("rst_mid_miss_count", miss_count, 32'd0);
`endif
            bus.mem_read_ready = 1'b1;
            bus.mem_read_data  = 32'h55555555;
            @(negedge clk);
            bus.mem_read_ready = 1'b0;
            repeat (4) @(negedge clk);
            check("late_ready_no_pulse", 32'(n_pulse - p0), 32'd0);
            check("late_ready_mem_valid", 32'(bus.mem_read_valid), 32'd0);
        end

        // Valid bits were cleared by reset: cold miss then hit again
        access('{12'h005, 1'b1, 32'h0C0FFEE0, 3, 1'b0, 1'b0, 0});
        access('{12'h005, 1'b0, 32'h0C0FFEE0, 0, 1'b0, 1'b0, 0});
`ifdef ICACHE_STATS_EN
        check("post_rst_hit_count", hit_count, 32'd1);
        check("post_rst_miss_count", miss_count, 32'd1);
`endif
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache between the fetcher and instruction memory.
- Presents the same valid/ready read interface to the fetcher that instruction memory does, so the fetcher is unchanged.
- On a miss it forwards the request to memory and fills one line (one instruction per line).
- Includes a flush input so the kernel loader can invalidate contents after rewriting program memory.

Parameters:
- ADDR_WIDTH, 12: instruction word-address width.
- INSTR_WIDTH, 32: instruction width in bits.
- NUM_LINES, 16: number of lines; must be a power of two and at least 2. INDEX_BITS = log2(NUM_LINES).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  invalidate all lines.
- fetch_read_valid  in  1  fetcher request.
- fetch_read_address  in  ADDR_WIDTH  fetcher word address.
- fetch_read_ready  out  1  one-cycle response pulse.
- fetch_read_data  out  INSTR_WIDTH  instruction; valid while fetch_read_ready=1.
- mem_read_valid  out  1  request to instruction memory.
- mem_read_address  out  ADDR_WIDTH  memory word address.
- mem_read_ready  in  1  memory response pulse.
- mem_read_data  in  INSTR_WIDTH  memory data; valid with mem_read_ready.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - state=IDLE.
  - All line valid bits = 0.
  - fetch_read_ready=0, fetch_read_data=0.
  - mem_read_valid=0, mem_read_address=0.
  - Tag/data arrays are not reset.
- Address split:
  - index = addr[INDEX_BITS-1:0].
  - tag = addr[ADDR_WIDTH-1:INDEX_BITS].
- All outputs are registered.
- FSM states: IDLE, LOOKUP, MISS, DONE.
  - IDLE: when fetch_read_valid=1, capture fetch_read_address into req_addr and go to LOOKUP. The address is ignored after capture.
  - LOOKUP: hit = valid[index] && tag match.
    - Hit: next cycle fetch_read_ready=1 and fetch_read_data=line data; go to DONE.
    - Miss: next cycle mem_read_valid=1 and mem_read_address=req_addr; go to MISS.
  - MISS: hold mem_read_valid and mem_read_address until mem_read_ready is sampled high. On that edge:
    - Write data and tag, set valid[index].
    - Next cycle: mem_read_valid=0, fetch_read_ready=1, fetch_read_data=mem_read_data.
    - Go to DONE.
  - DONE: wait until fetch_read_valid=0, then go to IDLE. This prevents a duplicate response when the fetcher still holds valid in the cycle after ready.
- Latency:
  - Hit: request sampled at edge N gives fetch_read_ready high in cycle N+2.
  - Miss: mem_read_ready sampled at edge M gives fetch_read_ready high in cycle M+1.
- fetch_read_ready is high for exactly one cycle per accepted request. fetch_read_data holds its value until the next response.
- flush:
  - Clears all valid bits at the edge where it is sampled.
  - Flush and fill on the same edge: flush wins and the line stays invalid, but the fetcher response is still delivered with the memory data.
  - Flush and LOOKUP on the same edge: lookup uses pre-flush valid bits.
  - Flush has no effect on the FSM.
- Reset mid-operation (any state): next cycle state=IDLE, mem_read_valid=0, no fetch_read_ready pulse.
  - A late mem_read_ready arriving after reset is ignored.
- mem_read_ready while not in MISS is ignored.
- Index wrap: addresses differing only in tag alias to one line; the newest fill replaces the old line.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds output ports hit_count (32 bits) and miss_count (32 bits).
  - Each counter increments once per LOOKUP resolved as a hit or a miss respectively.
  - Counters saturate at 0xFFFFFFFF.
  - reset clears them; flush does not.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, request address 0x005; memory answers with ready + 0xDEADBEEF three cycles after mem_read_valid rises.
  - Required: mem_read_address=0x005; fetch_read_ready pulses once, on the cycle after mem_read_ready, with data 0xDEADBEEF.
- Hit:
  - Stimulus: request 0x005 again after the cold miss.
  - Required: no mem_read_valid; fetch_read_ready at N+2 with 0xDEADBEEF.
- Aliasing:
  - Stimulus: request 0x015 (same index 5, NUM_LINES=16), fill with 0x12345678, then request 0x005.
  - Required: both requests miss; mem_read_address is 0x015, then 0x005.
- Flush:
  - Stimulus: fill 0x003, assert flush for one cycle, request 0x003.
  - Required: second access misses. Also flush on the fill edge → response still 0xCAFEF00D, and the next access to the same address misses.
- Held valid:
  - Stimulus: fetcher keeps fetch_read_valid high for 4 cycles after a hit response.
  - Required: exactly one fetch_read_ready pulse; the next request is accepted only after valid drops.
- Reset during MISS, plus stats:
  - Stimulus: assert reset for one cycle, then deliver mem_read_ready.
  - Required: mem_read_valid=0 the cycle after reset; no fetch_read_ready pulse.
  - With ICACHE_STATS_EN: hit_count=0 and miss_count=0 after reset, and 1/1 after one miss and one hit.
